// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration helpers for the staggered reset sequencer.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      Hold    = 2'd0,
      Release = 2'd1,
      Run     = 2'd2,
      Soft    = 2'd3
   } rst_seq_state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) begin
         m = b;
      end else begin
         m = m;
      end
      if (c > m) begin
         m = c;
      end else begin
         m = m;
      end
      return m;
   endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asserts asynchronously with rst_i, releases after
// SyncStages clock edges that sample rst_i low.
module rst_sync #(
   parameter int SyncStages = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic sync_rst_o
);

   logic [SyncStages-1:0] sync_q;
   logic [SyncStages-1:0] sync_d;

   // Shift a zero in from the bottom of the chain each cycle.
   always_comb begin
      sync_d = {sync_q[SyncStages-2:0], 1'b0};
   end

   // Chain register, forced to all ones while the raw reset is high.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign sync_rst_o = sync_q[SyncStages-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Staggered active-low reset sequencer with soft-reset request/ack handshake.
module rst_seq_gen
   import rst_seq_pkg::*;
#(
   parameter int NumChannels   = 4,
   parameter int SyncStages    = 2,
   parameter int RstClkCycles  = 4,
   parameter int ChanGapCycles = 2,
   parameter int SoftRstCycles = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   soft_rst_req_i,
   output logic                   soft_rst_ack_o,
   output logic [NumChannels-1:0] rst_no,
   output logic                   done_o
);

   localparam int CntW = $clog2(max3(RstClkCycles, SoftRstCycles, ChanGapCycles) + 1);
   localparam int IdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
   localparam logic [CntW-1:0] HoldLast = CntW'(RstClkCycles - 1);
   localparam logic [CntW-1:0] SoftLast = CntW'(SoftRstCycles - 1);
   localparam logic [CntW-1:0] GapLast  = CntW'((ChanGapCycles > 0) ? ChanGapCycles - 1 : 0);
   localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumChannels - 1);
   localparam bit              AllAtOnce = (ChanGapCycles == 0) || (NumChannels == 1);

   if (NumChannels < 1) begin : g_bad_num_channels
      $fatal(1, "rst_seq_gen: NumChannels must be >= 1");
   end
   if (SyncStages < 2) begin : g_bad_sync_stages
      $fatal(1, "rst_seq_gen: SyncStages must be >= 2");
   end
   if (RstClkCycles < 1) begin : g_bad_rst_clk_cycles
      $fatal(1, "rst_seq_gen: RstClkCycles must be >= 1");
   end
   if (ChanGapCycles < 0) begin : g_bad_chan_gap_cycles
      $fatal(1, "rst_seq_gen: ChanGapCycles must be >= 0");
   end
   if (SoftRstCycles < 1) begin : g_bad_soft_rst_cycles
      $fatal(1, "rst_seq_gen: SoftRstCycles must be >= 1");
   end

   logic                   sync_rst_s;
   rst_seq_state_e         state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc_s;
   logic [IdxW-1:0]        idx_q, idx_d, nxt_idx_s;
   logic [NumChannels-1:0] rst_q, rst_d;
   logic                   done_q, done_d;
   logic                   ack_q, ack_d;
   logic                   soft_seq_q, soft_seq_d;

   rst_sync #(
      .SyncStages(SyncStages)
   ) u_rst_sync (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .sync_rst_o (sync_rst_s)
   );

   // Saturating increment and next channel index.
   always_comb begin
      cnt_inc_s = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);
      nxt_idx_s = idx_q + IdxW'(1);
   end

   // Next-state logic: hold/soft countdown, staggered release, handshake.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_inc_s;
      idx_d      = idx_q;
      rst_d      = rst_q;
      done_d     = done_q;
      ack_d      = ack_q & soft_rst_req_i;
      soft_seq_d = soft_seq_q;
      case (state_q)
         Hold, Soft: begin
            if ((state_q == Hold && cnt_q == HoldLast) ||
                (state_q == Soft && cnt_q == SoftLast)) begin
               cnt_d    = '0;
               idx_d    = '0;
               rst_d[0] = 1'b1;
               state_d  = AllAtOnce ? Run : Release;
            end else begin
               state_d = state_q;
            end
         end
         Release: begin
            if (cnt_q == GapLast) begin
               cnt_d            = '0;
               idx_d            = nxt_idx_s;
               rst_d[nxt_idx_s] = 1'b1;
               state_d          = (nxt_idx_s == LastIdx) ? Run : Release;
            end else begin
               state_d = Release;
            end
         end
         Run: begin
            if (soft_rst_req_i && !ack_q) begin
               state_d    = Soft;
               cnt_d      = '0;
               rst_d      = '0;
               done_d     = 1'b0;
               soft_seq_d = 1'b1;
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = Hold;
            cnt_d   = '0;
         end
      endcase

      // Completion: every channel out, and a finished soft sequence raises ack with done.
      if (state_d == Run && state_q != Run) begin
         rst_d      = '1;
         done_d     = 1'b1;
         ack_d      = ack_d | soft_seq_q;
         soft_seq_d = 1'b0;
      end else begin
         soft_seq_d = soft_seq_d;
      end
   end

   // Sequencer registers, held in reset by the synchronised reset.
   always_ff @(posedge clk_i or posedge sync_rst_s) begin
      if (sync_rst_s) begin
         state_q    <= Hold;
         cnt_q      <= '0;
         idx_q      <= '0;
         rst_q      <= '0;
         done_q     <= 1'b0;
         ack_q      <= 1'b0;
         soft_seq_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         rst_q      <= rst_d;
         done_q     <= done_d;
         ack_q      <= ack_d;
         soft_seq_q <= soft_seq_d;
      end
   end

   assign rst_no         = rst_q;
   assign done_o         = done_q;
   assign soft_rst_ack_o = ack_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench: an edge-timeline model pushes expectations into a queue,
// which are popped and compared after each clock edge.
module tb_rst_seq_gen;

   localparam int N  = 4;
   localparam int S  = 2;
   localparam int R  = 4;
   localparam int G  = 2;
   localparam int SR = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req = 1'b0;
   logic         ack;
   logic [N-1:0] rst_n_o;
   logic         done;
   logic         ack2;
   logic [2:0]   rst_n_o2;
   logic         done2;

   always #5 clk = ~clk;

   rst_seq_gen #(
      .NumChannels(N), .SyncStages(S), .RstClkCycles(R),
      .ChanGapCycles(G), .SoftRstCycles(SR)
   ) dut (
      .clk_i(clk), .rst_i(rst), .soft_rst_req_i(req),
      .soft_rst_ack_o(ack), .rst_no(rst_n_o), .done_o(done)
   );

   rst_seq_gen #(
      .NumChannels(3), .SyncStages(S), .RstClkCycles(R),
      .ChanGapCycles(0), .SoftRstCycles(SR)
   ) dut2 (
      .clk_i(clk), .rst_i(rst), .soft_rst_req_i(1'b0),
      .soft_rst_ack_o(ack2), .rst_no(rst_n_o2), .done_o(done2)
   );

   typedef struct {
      logic [N-1:0] rst;
      logic         done;
      logic         ack;
      logic [2:0]   rst2;
      logic         done2;
   } exp_t;

   exp_t sb_q[$];
   int   n_pass = 0;
   int   n_fail = 0;
   int   n_tot  = 0;
   int   edge_n = 0;
   int   m_rel  = S + R;
   logic m_done = 1'b0;
   logic m_ack  = 1'b0;
   logic m_soft = 1'b0;

   task automatic check1(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_tot++;
      assert (obs === exp_v) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s at E%0d: observed %0h expected %0h", tag, edge_n, obs, exp_v);
      end
   endtask

   task automatic compare_pop();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_tot++;
         n_fail++;
         $error("FAIL scoreboard_empty at E%0d", edge_n);
      end else begin
         e = sb_q.pop_front();
         check1("rst_no",  8'(rst_n_o),  8'(e.rst));
         check1("done_o",  8'(done),     8'(e.done));
         check1("ack_o",   8'(ack),      8'(e.ack));
         check1("rst_no2", 8'(rst_n_o2), 8'(e.rst2));
         check1("done_o2", 8'(done2),    8'(e.done2));
         check1("ack_o2",  8'(ack2),     8'd0);
      end
   endtask

   task automatic push_reset_state();
      exp_t e;
      e = '{default: '0};
      sb_q.push_back(e);
   endtask

   task automatic model_restart();
      edge_n = 0;
      m_rel  = S + R;
      m_done = 1'b0;
      m_ack  = 1'b0;
      m_soft = 1'b0;
   endtask

   // Predict the outputs after the coming edge from the release timeline.
   task automatic predict();
      exp_t e;
      int   n;
      n = edge_n + 1;
      e = '{default: '0};
      if (m_done && req && !m_ack) begin
         m_rel  = n + SR;
         m_soft = 1'b1;
      end
      for (int k = 0; k < N; k++) begin
         e.rst[k] = (n >= m_rel + k * G);
      end
      e.done = &e.rst;
      if (e.done && !m_done && m_soft) begin
         e.ack  = 1'b1;
         m_soft = 1'b0;
      end else begin
         e.ack = m_ack && req;
      end
      m_done  = e.done;
      m_ack   = e.ack;
      e.rst2  = (n >= S + R) ? 3'b111 : 3'b000;
      e.done2 = (n >= S + R);
      sb_q.push_back(e);
   endtask

   task automatic step();
      predict();
      @(posedge clk);
      #1;
      edge_n++;
      compare_pop();
   endtask

   initial begin
      repeat (3) begin
         @(posedge clk);
         #1;
         push_reset_state();
         compare_pop();
      end
      @(negedge clk);
      rst = 1'b0;
      model_restart();

      repeat (19) step();
      req = 1'b1;
      repeat (20) step();
      req = 1'b0;
      repeat (6) step();
      req = 1'b1;
      repeat (4) step();

      rst = 1'b1;
      #1;
      push_reset_state();
      compare_pop();
      #1;
      rst = 1'b0;
      model_restart();

      repeat (30) step();
      req = 1'b0;
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
